// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - host command loader for cpu imem/dmem ports and run control
// Define MEM_LOADER_IMEM_READBACK_EN to make op 100 an imem read; otherwise it is illegal.
module mem_loader #(
  parameter int RUN_W = 32
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [63:0] cmd_addr,
  input  logic [63:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  input  logic [31:0] rdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        enable,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, WRITE, READ_REQ, READ_WAIT, RUN, RESP} state_t;

`ifdef MEM_LOADER_IMEM_READBACK_EN
  localparam bit IMEM_RD_EN = 1'b1;
`else
  localparam bit IMEM_RD_EN = 1'b0;
`endif

  state_t           state;
  logic [2:0]       op_r;
  logic [RUN_W-1:0] cnt;
  logic             illegal;
  logic [RUN_W-1:0] run_len;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign run_len   = cmd_data[RUN_W-1:0];
  assign illegal   = (cmd_op > 3'b100) || ((cmd_op == 3'b100) && !IMEM_RD_EN);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= IDLE;
      op_r        <= 3'b000;
      cnt         <= '0;
      enable      <= 1'b0;
      wen_ext     <= 1'b0;
      ren_ext     <= 1'b0;
      wen_ext_2   <= 1'b0;
      ren_ext_2   <= 1'b0;
      addr_ext    <= '0;
      addr_ext_2  <= '0;
      wdata_ext   <= '0;
      wdata_ext_2 <= '0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_data    <= '0;
    end else begin
      wen_ext   <= 1'b0;
      ren_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;
      ren_ext_2 <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_r <= cmd_op;
            if (illegal) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
            end else begin
              case (cmd_op)
                3'b000: begin
                  state     <= WRITE;
                  wen_ext   <= 1'b1;
                  addr_ext  <= cmd_addr;
                  wdata_ext <= cmd_data[31:0];
                end
                3'b001: begin
                  state       <= WRITE;
                  wen_ext_2   <= 1'b1;
                  addr_ext_2  <= cmd_addr;
                  wdata_ext_2 <= cmd_data;
                end
                3'b010: begin
                  state      <= READ_REQ;
                  ren_ext_2  <= 1'b1;
                  addr_ext_2 <= cmd_addr;
                end
                3'b011: begin
                  // Run length goes straight into rsp_data so completion only flips rsp_valid.
                  rsp_data <= 64'(run_len);
                  rsp_err  <= 1'b0;
                  cnt      <= run_len;
                  if (run_len != '0) begin
                    state  <= RUN;
                    enable <= 1'b1;
                  end else begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                  end
                end
                default: begin
                  state    <= READ_REQ;
                  ren_ext  <= 1'b1;
                  addr_ext <= cmd_addr;
                end
              endcase
            end
          end
        end
        WRITE:    state <= IDLE;
        READ_REQ: state <= READ_WAIT;
        READ_WAIT: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_data  <= (op_r == 3'b100) ? {32'b0, rdata_ext} : rdata_ext_2;
        end
        RUN: begin
          if (cnt == RUN_W'(1)) begin
            enable    <= 1'b0;
            state     <= RESP;
            rsp_valid <= 1'b1;
          end
          cnt <= cnt - RUN_W'(1);
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
